// File: rtl/fb_pattern_gen.sv
// Framebuffer test-pattern writer: walks an H_ACTIVE x V_ACTIVE frame in raster
// order and issues one valid/ready write per pixel (solid, bars, checkerboard, ramp).
module fb_pattern_gen #(
    parameter int                  H_ACTIVE    = 640,
    parameter int                  V_ACTIVE    = 400,
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 8,
    parameter int                  NBARS       = 3,
    parameter logic [4*DATA_W-1:0] BAR_PALETTE = {8'hFF, 8'h03, 8'h1C, 8'hE0},
    parameter int                  CELL_LOG2   = 4
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fg,
    input  logic [DATA_W-1:0] bg,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              wr_ready,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);
    localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BARW = (NBARS > 1) ? $clog2(NBARS) : 1;
    localparam int BW   = H_ACTIVE / NBARS;

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t            state, state_n;
    logic [XW-1:0]     x, x_n, cnt, cnt_n;
    logic [YW-1:0]     y, y_n;
    logic [ADDR_W-1:0] lin, lin_n;
    logic [BARW-1:0]   bar, bar_n;
    logic [1:0]        mode_l, mode_s;
    logic [DATA_W-1:0] fg_l, bg_l, fg_s, bg_s;
    logic [ADDR_W-1:0] base_l, base_s;
    logic              load, adv;

    function automatic logic [DATA_W-1:0] pix_data(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] fgc,
        input logic [DATA_W-1:0] bgc,
        input logic [XW-1:0]     xv,
        input logic [YW-1:0]     yv,
        input logic [BARW-1:0]   bv,
        input logic [ADDR_W-1:0] lv
    );
        logic [31:0] xe, ye;
        int          idx;
        xe  = 32'(xv);
        ye  = 32'(yv);
        idx = int'(bv) % 4;
        case (m)
            2'd0:    return fgc;
            2'd1:    return BAR_PALETTE[idx*DATA_W +: DATA_W];
            2'd2:    return (xe[CELL_LOG2] ^ ye[CELL_LOG2]) ? bgc : fgc;
            default: return DATA_W'(lv);
        endcase
    endfunction

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-pixel counters; the bar index advances by counting, not dividing.
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        lin_n   = lin;
        bar_n   = bar;
        cnt_n   = cnt;
        load    = 1'b0;
        adv     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = FILL;
                    load    = 1'b1;
                    x_n     = '0;
                    y_n     = '0;
                    lin_n   = '0;
                    bar_n   = '0;
                    cnt_n   = '0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (wr_ready) begin
                    adv   = 1'b1;
                    lin_n = lin + ADDR_W'(1);
                    if (x == XW'(H_ACTIVE - 1)) begin
                        x_n   = '0;
                        y_n   = y + YW'(1);
                        bar_n = '0;
                        cnt_n = '0;
                        if (y == YW'(V_ACTIVE - 1)) state_n = DONE;
                    end else begin
                        x_n = x + XW'(1);
                        if (bar < BARW'(NBARS - 1) && cnt == XW'(BW - 1)) begin
                            bar_n = bar + BARW'(1);
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt + XW'(1);
                        end
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // On start the pixel-(0,0) word is built from the live inputs being latched.
    assign mode_s = load ? mode      : mode_l;
    assign fg_s   = load ? fg        : fg_l;
    assign bg_s   = load ? bg        : bg_l;
    assign base_s = load ? base_addr : base_l;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            lin     <= '0;
            bar     <= '0;
            cnt     <= '0;
            mode_l  <= '0;
            fg_l    <= '0;
            bg_l    <= '0;
            base_l  <= '0;
            wr      <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            x   <= x_n;
            y   <= y_n;
            lin <= lin_n;
            bar <= bar_n;
            cnt <= cnt_n;
            if (load) begin
                mode_l <= mode;
                fg_l   <= fg;
                bg_l   <= bg;
                base_l <= base_addr;
            end
            if (load || adv) begin
                wr_addr <= base_s + lin_n;
                wr_data <= pix_data(mode_s, fg_s, bg_s, x_n, y_n, bar_n, lin_n);
            end
            wr   <= (state_n == FILL);
            busy <= (state_n == FILL);
            done <= (state_n == DONE);
        end
    end
endmodule
